// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited request issue, in-order
// response capture into a prefetch queue, and redirect-driven flush.
module fetch_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic            run;
  logic [CW:0]     credit_sum;
  logic            grant;
  logic            rsp;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [XLEN-1:0] q_inst [DEPTH];

  // Credit covers queued plus in-flight words, so the queue cannot overflow.
  assign credit_sum = {1'b0, count} + {1'b0, inflight};
  assign imem_req   = run && !redirect
                   && (credit_sum < (CW+1)'(DEPTH));
  assign imem_addr  = fetch_pc;

  assign grant = imem_req && imem_gnt;
  assign rsp   = imem_rvalid && (inflight != '0);
  assign push  = rsp && (discard == '0) && !redirect;
  assign pop   = id_valid && !stall && !redirect;

  assign id_valid = (count != '0);
  assign id_pc    = id_valid ? q_pc[head]   : '0;
  assign id_inst  = id_valid ? q_inst[head] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run      <= 1'b0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      head     <= '0;
      tail     <= '0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        count    <= '0;
        head     <= '0;
        tail     <= '0;
        inflight <= inflight - CW'(rsp);
        discard  <= inflight - CW'(rsp);
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        inflight <= inflight + CW'(grant) - CW'(rsp);
        count    <= count + CW'(push) - CW'(pop);
        if (rsp && (discard != '0))
          discard <= discard - CW'(1);
        if (push) begin
          tail    <= tail + AW'(1);
          resp_pc <= resp_pc + XLEN'(4);
        end
        if (pop)
          head <= head + AW'(1);
        if (grant)
          fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[tail]   <= resp_pc;
      q_inst[tail] <= imem_rdata;
    end
  end

  a_rvalid_legal: assert property (
    @(posedge clock) disable iff (reset)
    !(imem_rvalid && (inflight == '0))
  );

endmodule
